// File: rtl/SB_codex_pkg.sv
// SB_codex_pkg: sideband message type, rx state enum and header decoder
package SB_codex_pkg;
   typedef enum logic [3:0] {
      SB_NONE         = 4'd0,
      SB_OOR          = 4'd1,
      SB_DONE_REQ     = 4'd2,
      SB_DONE_RESP    = 4'd3,
      SB_PARAM_REQ    = 4'd4,
      SB_PARAM_RESP   = 4'd5,
      SB_PATTERN_REQ  = 4'd6,
      SB_PATTERN_RESP = 4'd7
   } SB_msg_t;
   typedef enum logic [1:0] {SB_RX_IDLE, SB_RX_RECEIVING, SB_RX_GAP} sb_rx_state_t;
   typedef struct packed {
      SB_msg_t msg;
      logic    valid;
      logic    expect_32b;
      logic    expect_64b;
   } sb_dec_t;
   localparam logic [4:0] op_nodata = 5'b10010;
   localparam logic [4:0] op_data32 = 5'b11001;
   localparam logic [4:0] op_data64 = 5'b11011;
   localparam int msg_w = $bits(SB_msg_t);
   // Header layout: [4:0] opcode, [15:8] msgcode, [23:16] msgsubcode, every other bit zero.
   function automatic sb_dec_t decode_SB_msg(input logic [63:0] hdr);
      sb_dec_t d;
      d = '{SB_NONE, 1'b0, 1'b0, 1'b0};
      if (hdr[63:24] == '0 && hdr[7:5] == '0)
         case ({hdr[4:0], hdr[15:8], hdr[23:16]})
            {op_nodata, 8'h91, 8'h00}: d = '{SB_OOR,          1'b1, 1'b0, 1'b0};
            {op_nodata, 8'h95, 8'h01}: d = '{SB_DONE_REQ,     1'b1, 1'b0, 1'b0};
            {op_nodata, 8'h9A, 8'h01}: d = '{SB_DONE_RESP,    1'b1, 1'b0, 1'b0};
            {op_data32, 8'hA5, 8'h00}: d = '{SB_PARAM_REQ,    1'b1, 1'b1, 1'b0};
            {op_data32, 8'hAA, 8'h00}: d = '{SB_PARAM_RESP,   1'b1, 1'b1, 1'b0};
            {op_data64, 8'hB5, 8'h02}: d = '{SB_PATTERN_REQ,  1'b1, 1'b0, 1'b1};
            {op_data64, 8'hBA, 8'h02}: d = '{SB_PATTERN_RESP, 1'b1, 1'b0, 1'b1};
            default:                   d = '{SB_NONE,         1'b0, 1'b0, 1'b0};
         endcase
      return d;
   endfunction
endpackage

// File: rtl/sb_rx_deser_if.sv
// sb_rx_deser_if: message FIFO head handshake between the sideband receiver and the LTSM
interface sb_rx_deser_if;
   import SB_codex_pkg::*;
   SB_msg_t     msg_o;
   logic [63:0] dataBus_o;
   logic        valid_o;
   logic        ready_i;
   modport master (output msg_o, dataBus_o, valid_o, input ready_i);
   modport slave  (input msg_o, dataBus_o, valid_o, output ready_i);
endinterface

// File: rtl/sb_rx_fifo.sv
// sb_rx_fifo: synchronous show-ahead FIFO; a push into a full FIFO is refused unless a pop frees a slot
module sb_rx_fifo #(
   parameter int depth = 4,
   parameter int width = 68
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [width-1:0] push_data,
   input  logic             pop,
   output logic [width-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int aw = (depth > 1) ? $clog2(depth) : 1;
   logic [width-1:0] mem [depth];
   logic [aw-1:0] wr_ptr, rd_ptr;
   logic [aw:0] count;
   logic do_push, do_pop;
   assign full    = count == (aw+1)'(depth);
   assign empty   = count == '0;
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];
   // pointers wrap naturally since depth is a power of two
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + aw'(do_push);
         rd_ptr <= rd_ptr + aw'(do_pop);
         count  <= count + (aw+1)'(do_push) - (aw+1)'(do_pop);
      end
   // storage carries no reset: the head is only consumed while non-empty
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/sb_rx_deser.sv
// sb_rx_deser: sideband receiver - deserialises 64-UI packets, enforces the 32-UI gap, decodes
// headers, merges data payloads and queues messages. Optional SB_RX_ERR_CNT_EN adds err_cnt_o.
module sb_rx_deser
   import SB_codex_pkg::*;
#(
   parameter int fifo_depth = 4
) (
   input  logic          clk_800MHz,
   input  logic          reset,
   input  logic          enable_i,
   input  logic          dataPin_i,
   input  logic          dataVld_i,
   sb_rx_deser_if.master bus,
   output logic          frame_err_o,
   output logic          decode_err_o,
   output logic          overflow_o
`ifdef SB_RX_ERR_CNT_EN
   ,
   output logic [15:0]   err_cnt_o
`endif
);
   sb_rx_state_t state, state_nx;
   logic [5:0] ctr_64, ctr64_nx, bit_idx;
   logic [4:0] ctr_32, ctr32_nx;
   logic [63:0] shreg, push_data;
   logic store, done, done_nx, ferr_nx;
   logic push_vld, pend32, pend64, pop, full, empty;
   SB_msg_t push_msg, held_msg;
   logic [msg_w+63:0] head;
   sb_dec_t dec;
   assign bit_idx = (state == SB_RX_RECEIVING) ? ctr_64 : 6'd0;
   assign dec     = decode_SB_msg(shreg);
   assign pop     = !empty && bus.ready_i;
   assign bus.valid_o   = !empty;
   assign bus.msg_o     = empty ? SB_NONE : SB_msg_t'(head[msg_w+63:64]);
   assign bus.dataBus_o = empty ? 64'd0 : head[63:0];
   // next state: a valid UI in GAP restarts reception as bit 0 but flags the short gap
   always_comb begin
      state_nx = state;
      ctr64_nx = ctr_64;
      ctr32_nx = ctr_32;
      store    = 1'b0;
      done_nx  = 1'b0;
      ferr_nx  = 1'b0;
      if (!enable_i) begin
         state_nx = SB_RX_IDLE;
         ctr64_nx = '0;
         ctr32_nx = '0;
      end else
         case (state)
            SB_RX_IDLE:
               if (dataVld_i) begin
                  store    = 1'b1;
                  ctr64_nx = 6'd1;
                  state_nx = SB_RX_RECEIVING;
               end
            SB_RX_RECEIVING:
               if (!dataVld_i) begin
                  ferr_nx  = 1'b1;
                  ctr64_nx = '0;
                  state_nx = SB_RX_IDLE;
               end else begin
                  store    = 1'b1;
                  ctr64_nx = ctr_64 + 6'd1;
                  if (ctr_64 == 6'd63) begin
                     done_nx  = 1'b1;
                     ctr32_nx = '0;
                     state_nx = SB_RX_GAP;
                  end
               end
            SB_RX_GAP:
               if (dataVld_i) begin
                  ferr_nx  = 1'b1;
                  store    = 1'b1;
                  ctr64_nx = 6'd1;
                  state_nx = SB_RX_RECEIVING;
               end else begin
                  ctr32_nx = ctr_32 + 5'd1;
                  if (ctr_32 == 5'd31) state_nx = SB_RX_IDLE;
               end
            default: state_nx = SB_RX_IDLE;
         endcase
   end
   // state register, UI counters, shift register and frame-error pulse
   always_ff @(posedge clk_800MHz or negedge reset)
      if (!reset) begin
         state       <= SB_RX_IDLE;
         ctr_64      <= '0;
         ctr_32      <= '0;
         shreg       <= '0;
         done        <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         state       <= state_nx;
         ctr_64      <= ctr64_nx;
         ctr_32      <= ctr32_nx;
         if (store) shreg[bit_idx] <= dataPin_i;
         done        <= done_nx;
         frame_err_o <= ferr_nx;
      end
   // assembler: a packet after a data-bearing header is its payload, otherwise it is a header
   always_ff @(posedge clk_800MHz or negedge reset)
      if (!reset) begin
         push_vld     <= 1'b0;
         push_msg     <= SB_NONE;
         push_data    <= '0;
         held_msg     <= SB_NONE;
         pend32       <= 1'b0;
         pend64       <= 1'b0;
         decode_err_o <= 1'b0;
         overflow_o   <= 1'b0;
      end else begin
         push_vld     <= 1'b0;
         decode_err_o <= 1'b0;
         overflow_o   <= push_vld && full && !pop;
         if (!enable_i) begin
            pend32 <= 1'b0;
            pend64 <= 1'b0;
         end else if (done && (pend32 || pend64)) begin
            push_vld  <= 1'b1;
            push_msg  <= held_msg;
            push_data <= pend64 ? shreg : {32'd0, shreg[31:0]};
            pend32    <= 1'b0;
            pend64    <= 1'b0;
         end else if (done) begin
            held_msg     <= dec.msg;
            push_msg     <= dec.msg;
            push_data    <= '0;
            decode_err_o <= !dec.valid;
            pend32       <= dec.expect_32b;
            pend64       <= dec.expect_64b;
            push_vld     <= dec.valid && !dec.expect_32b && !dec.expect_64b;
         end
      end
   sb_rx_fifo #(.depth(fifo_depth), .width(msg_w + 64)) u_fifo (
      .clk(clk_800MHz),
      .reset(reset),
      .push(push_vld),
      .push_data({push_msg, push_data}),
      .pop(pop),
      .head(head),
      .full(full),
      .empty(empty)
   );
`ifdef SB_RX_ERR_CNT_EN
   logic [1:0] ev;
   assign ev = {1'b0, frame_err_o} + {1'b0, decode_err_o} + {1'b0, overflow_o};
   // saturating error-event counter, held clear while the receiver is disabled
   always_ff @(posedge clk_800MHz or negedge reset)
      if (!reset) err_cnt_o <= '0;
      else if (!enable_i) err_cnt_o <= '0;
      else err_cnt_o <= (err_cnt_o > 16'hFFFF - 16'(ev)) ? 16'hFFFF : err_cnt_o + 16'(ev);
`endif
endmodule

// File: tb/tb_sb_rx_deser.sv
// tb_sb_rx_deser: directed self-checking bench for the sideband receiver
module tb_sb_rx_deser;
   import SB_codex_pkg::*;
   localparam logic [63:0] h_oor         = 64'h0000_0000_0000_9112;
   localparam logic [63:0] h_done_req    = 64'h0000_0000_0001_9512;
   localparam logic [63:0] h_done_resp   = 64'h0000_0000_0001_9A12;
   localparam logic [63:0] h_param_req   = 64'h0000_0000_0000_A519;
   localparam logic [63:0] h_pattern_req = 64'h0000_0000_0002_B51B;
   logic clk = 1'b0, reset = 1'b0, enable_i = 1'b0, dataPin_i = 1'b0, dataVld_i = 1'b0;
   logic frame_err_o, decode_err_o, overflow_o;
   int errors = 0, checks = 0, n_ferr = 0, n_derr = 0, n_ovf = 0;
`ifdef SB_RX_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif
   sb_rx_deser_if bus();
   sb_rx_deser #(.fifo_depth(4)) dut (
      .clk_800MHz(clk),
      .reset(reset),
      .enable_i(enable_i),
      .dataPin_i(dataPin_i),
      .dataVld_i(dataVld_i),
      .bus(bus),
`ifdef SB_RX_ERR_CNT_EN
      .err_cnt_o(err_cnt),
`endif
      .frame_err_o(frame_err_o),
      .decode_err_o(decode_err_o),
      .overflow_o(overflow_o)
   );
   always #5 clk = ~clk;
   // tally error pulses once per cycle, away from the active edge
   always @(negedge clk) begin
      if (frame_err_o) n_ferr++;
      if (decode_err_o) n_derr++;
      if (overflow_o) n_ovf++;
   end
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic send_bits(input logic [63:0] p, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         dataVld_i = 1'b1;
         dataPin_i = p[i];
      end
      @(negedge clk);
      dataVld_i = 1'b0;
      dataPin_i = 1'b0;
   endtask
   task automatic pop_one;
      @(negedge clk);
      bus.ready_i = 1'b1;
      @(negedge clk);
      bus.ready_i = 1'b0;
   endtask
   task automatic test_reset;
      bus.ready_i = 1'b0;
      enable_i = 1'b1;
      idle(3);
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
      checks++; if (bus.msg_o !== SB_NONE) begin errors++; $display("FAIL reset_msg: got %0d want 0", bus.msg_o); end
      checks++; if (bus.dataBus_o !== 64'd0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.dataBus_o); end
      checks++; if ({frame_err_o, decode_err_o, overflow_o} !== 3'b000) begin errors++; $display("FAIL reset_err: got %b want 000", {frame_err_o, decode_err_o, overflow_o}); end
      reset = 1'b1;
      idle(2);
   endtask
   task automatic test_header_only;
      send_bits(h_done_req, 64);
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL hdr_lat0: got %b want 0", bus.valid_o); end
      idle(1);
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL hdr_lat1: got %b want 0", bus.valid_o); end
      idle(1);
      checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL hdr_lat2: got %b want 1", bus.valid_o); end
      checks++; if (bus.msg_o !== SB_DONE_REQ) begin errors++; $display("FAIL hdr_msg: got %0d want %0d", bus.msg_o, SB_DONE_REQ); end
      checks++; if (bus.dataBus_o !== 64'd0) begin errors++; $display("FAIL hdr_data: got %h want 0", bus.dataBus_o); end
      idle(30);
      pop_one();
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL hdr_pop: got %b want 0", bus.valid_o); end
   endtask
   task automatic test_data64;
      send_bits(h_pattern_req, 64);
      idle(32);
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL d64_held: got %b want 0", bus.valid_o); end
      send_bits(64'hDEADBEEF_CAFEF00D, 64);
      idle(2);
      checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL d64_valid: got %b want 1", bus.valid_o); end
      checks++; if (bus.msg_o !== SB_PATTERN_REQ) begin errors++; $display("FAIL d64_msg: got %0d want %0d", bus.msg_o, SB_PATTERN_REQ); end
      checks++; if (bus.dataBus_o !== 64'hDEADBEEF_CAFEF00D) begin errors++; $display("FAIL d64_data: got %h want deadbeefcafef00d", bus.dataBus_o); end
      idle(30);
      pop_one();
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL d64_pop: got %b want 0", bus.valid_o); end
   endtask
   task automatic test_data32;
      send_bits(h_param_req, 64);
      idle(32);
      send_bits(64'hAAAA_BBBB_1234_5678, 64);
      idle(2);
      checks++; if (bus.msg_o !== SB_PARAM_REQ) begin errors++; $display("FAIL d32_msg: got %0d want %0d", bus.msg_o, SB_PARAM_REQ); end
      checks++; if (bus.dataBus_o !== 64'h0000_0000_1234_5678) begin errors++; $display("FAIL d32_data: got %h want 0000000012345678", bus.dataBus_o); end
      idle(30);
      pop_one();
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL d32_pop: got %b want 0", bus.valid_o); end
   endtask
   task automatic test_frame_err;
      int f0;
      f0 = n_ferr;
      send_bits(h_done_req, 40);
      idle(40);
      checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL short_pkt_ferr: got %0d pulses want 1", n_ferr - f0); end
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL short_pkt_entry: got %b want 0", bus.valid_o); end
      f0 = n_ferr;
      send_bits(h_oor, 64);
      idle(9);
      send_bits(h_done_resp, 64);
      idle(2);
      checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL gap_ferr: got %0d pulses want 1", n_ferr - f0); end
      checks++; if (bus.msg_o !== SB_OOR) begin errors++; $display("FAIL gap_first: got %0d want %0d", bus.msg_o, SB_OOR); end
      idle(30);
      pop_one();
      checks++; if (bus.msg_o !== SB_DONE_RESP) begin errors++; $display("FAIL gap_second: got %0d want %0d", bus.msg_o, SB_DONE_RESP); end
      pop_one();
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL gap_empty: got %b want 0", bus.valid_o); end
   endtask
   task automatic test_decode_err;
      int d0, f0;
      d0 = n_derr;
      f0 = n_ferr;
      send_bits(64'hFFFF_FFFF_FFFF_FFFF, 64);
      idle(32);
      checks++; if (n_derr - d0 !== 1) begin errors++; $display("FAIL dec_err: got %0d pulses want 1", n_derr - d0); end
      checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL dec_ferr: got %0d pulses want 0", n_ferr - f0); end
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL dec_entry: got %b want 0", bus.valid_o); end
   endtask
   task automatic test_back_to_back;
      logic [63:0] hdr [5];
      SB_msg_t exp [4];
      int o0;
      hdr = '{h_oor, h_done_req, h_done_resp, h_oor, h_done_resp};
      exp = '{SB_OOR, SB_DONE_REQ, SB_DONE_RESP, SB_OOR};
      o0 = n_ovf;
      for (int i = 0; i < 4; i++) begin
         send_bits(hdr[i], 64);
         idle(32);
      end
      checks++; if (n_ovf - o0 !== 0) begin errors++; $display("FAIL bp_early_ovf: got %0d pulses want 0", n_ovf - o0); end
      send_bits(hdr[4], 64);
      idle(32);
      checks++; if (n_ovf - o0 !== 1) begin errors++; $display("FAIL bp_ovf: got %0d pulses want 1", n_ovf - o0); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus.msg_o !== exp[i]) begin errors++; $display("FAIL bp_order%0d: got %0d want %0d", i, bus.msg_o, exp[i]); end
         pop_one();
      end
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", bus.valid_o); end
   endtask
   task automatic test_enable;
      int f0, d0;
      f0 = n_ferr;
      d0 = n_derr;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         dataVld_i = 1'b1;
         dataPin_i = h_done_resp[i];
      end
      @(negedge clk);
      enable_i = 1'b0;
      idle(5);
      dataVld_i = 1'b0;
      idle(3);
      enable_i = 1'b1;
      idle(2);
      send_bits(h_done_req, 64);
      idle(2);
      checks++; if (n_ferr - f0 !== 0 || n_derr - d0 !== 0) begin errors++; $display("FAIL en_errs: got %0d/%0d pulses want 0/0", n_ferr - f0, n_derr - d0); end
      checks++; if (bus.msg_o !== SB_DONE_REQ || bus.valid_o !== 1'b1) begin errors++; $display("FAIL en_entry: got msg %0d valid %b want %0d 1", bus.msg_o, bus.valid_o, SB_DONE_REQ); end
      idle(30);
      pop_one();
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL en_single: got %b want 0", bus.valid_o); end
      send_bits(h_pattern_req, 64);
      idle(32);
      enable_i = 1'b0;
      idle(3);
      enable_i = 1'b1;
      idle(1);
      send_bits(h_done_resp, 64);
      idle(2);
      checks++; if (bus.msg_o !== SB_DONE_RESP || bus.dataBus_o !== 64'd0) begin errors++; $display("FAIL en_pending: got msg %0d data %h want %0d 0", bus.msg_o, bus.dataBus_o, SB_DONE_RESP); end
      idle(30);
      pop_one();
   endtask
   task automatic test_reset_mid;
      send_bits(h_oor, 64);
      idle(32);
      checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL rst_preload: got %b want 1", bus.valid_o); end
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         dataVld_i = 1'b1;
         dataPin_i = h_done_req[i];
      end
      #2 reset = 1'b0;
      #1;
      checks++; if ({bus.valid_o, frame_err_o, decode_err_o, overflow_o} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags: got %b want 0000", {bus.valid_o, frame_err_o, decode_err_o, overflow_o}); end
      checks++; if (bus.msg_o !== SB_NONE || bus.dataBus_o !== 64'd0) begin errors++; $display("FAIL rst_mid_bus: got %0d %h want 0 0", bus.msg_o, bus.dataBus_o); end
      @(negedge clk);
      dataVld_i = 1'b0;
      reset = 1'b1;
      idle(2);
      send_bits(h_done_req, 64);
      idle(2);
      checks++; if (bus.valid_o !== 1'b1 || bus.msg_o !== SB_DONE_REQ) begin errors++; $display("FAIL rst_after: got valid %b msg %0d want 1 %0d", bus.valid_o, bus.msg_o, SB_DONE_REQ); end
      idle(30);
      pop_one();
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL rst_after_pop: got %b want 0", bus.valid_o); end
   endtask
   initial begin
      test_reset();
      test_header_only();
      test_data64();
      test_data32();
      test_frame_err();
      test_decode_err();
      test_back_to_back();
      test_enable();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
